// File: rtl/zigzag_pkg.sv
// Shared definitions for the zigzag / inverse_zigzag coefficient reorder blocks.
//   BLOCK_N  : coefficients per 8x8 block
//   CNT_LAST : final position counter value within a block
//   ZZ_ORDER : zigzag position k -> natural column-major index (n = 8*col + row)
//   bank_e   : ping-pong bank selector
package zigzag_pkg;

  localparam int unsigned BLOCK_N = 64;

  localparam logic [5:0] CNT_LAST = 6'(BLOCK_N - 1);

  localparam logic [5:0] ZZ_ORDER [BLOCK_N] = '{
    6'd0,  6'd8,  6'd1,  6'd2,  6'd9,  6'd16, 6'd24, 6'd17,
    6'd10, 6'd3,  6'd4,  6'd11, 6'd18, 6'd25, 6'd32, 6'd40,
    6'd33, 6'd26, 6'd19, 6'd12, 6'd5,  6'd6,  6'd13, 6'd20,
    6'd27, 6'd34, 6'd41, 6'd48, 6'd56, 6'd49, 6'd42, 6'd35,
    6'd28, 6'd21, 6'd14, 6'd7,  6'd15, 6'd22, 6'd29, 6'd36,
    6'd43, 6'd50, 6'd57, 6'd58, 6'd51, 6'd44, 6'd37, 6'd30,
    6'd23, 6'd31, 6'd38, 6'd45, 6'd52, 6'd59, 6'd60, 6'd53,
    6'd46, 6'd39, 6'd47, 6'd54, 6'd61, 6'd62, 6'd55, 6'd63
  };

  typedef enum logic {
    BANK_0 = 1'b0,
    BANK_1 = 1'b1
  } bank_e;

  function automatic bank_e other_bank(input bank_e b);
    return (b == BANK_0) ? BANK_1 : BANK_0;
  endfunction

endpackage

// File: rtl/pingpong_bank.sv
// Two-bank coefficient store for ping-pong reordering.
//   clk          : write clock
//   i_we         : write enable
//   i_wr_bank    : bank selected for write
//   i_wr_addr    : entry address within the write bank
//   i_wr_data    : data written
//   i_rd_bank    : bank selected for read
//   i_rd_addr    : entry address within the read bank
//   o_rd_data    : asynchronous read data
// Contents are deliberately not reset.
module pingpong_bank
  import zigzag_pkg::*;
#(
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic             i_wr_bank,
  input  logic [5:0]       i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_bank,
  input  logic [5:0]       i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [2][BLOCK_N];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_bank][i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_bank][i_rd_addr];

endmodule

// File: rtl/inverse_zigzag.sv
// Inverse zigzag reorder: accepts 8x8 coefficient blocks in JPEG zigzag order
// and emits them in natural column-major order (n = 8*col + row). Ping-pong
// buffered so one bank fills while the other drains at one coefficient/cycle.
//   clk     : clock, all state on posedge
//   rst_n   : asynchronous active-low reset
//   in      : coefficient input, zigzag order
//   ena_in  : upstream valid
//   rdy_out : ready to upstream
//   out     : coefficient output, natural order ('0 when not valid)
//   ena_out : valid to downstream
//   rdy_in  : downstream ready
module inverse_zigzag
  import zigzag_pkg::*;
#(
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             ena_in,
  output logic             rdy_out,
  output logic [WIDTH-1:0] out,
  output logic             ena_out,
  input  logic             rdy_in
);

  logic [1:0]       r_full;
  bank_e            r_wr_bank;
  logic [5:0]       r_wr_cnt;
  bank_e            r_rd_bank;
  logic [5:0]       r_rd_cnt;

  logic             w_in_beat;
  logic             w_out_beat;
  logic [1:0]       w_full_nxt;
  logic [5:0]       w_wr_addr;
  logic [WIDTH-1:0] w_rd_data;

  assign rdy_out    = ~r_full[r_wr_bank];
  assign ena_out    = r_full[r_rd_bank];
  assign w_in_beat  = ena_in & rdy_out;
  assign w_out_beat = ena_out & rdy_in;

  // Scatter on write, linear on read: the zigzag position maps to the
  // natural-order slot, so the drain side simply counts 0..63.
  assign w_wr_addr  = ZZ_ORDER[r_wr_cnt];

  assign out = ena_out ? w_rd_data : '0;

  // The last write and last read of a cycle always hit different banks,
  // so both flag updates are applied independently.
  always_comb begin
    w_full_nxt = r_full;
    if (w_in_beat && (r_wr_cnt == CNT_LAST)) begin
      w_full_nxt[r_wr_bank] = 1'b1;
    end
    if (w_out_beat && (r_rd_cnt == CNT_LAST)) begin
      w_full_nxt[r_rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full    <= '0;
      r_wr_bank <= BANK_0;
      r_wr_cnt  <= '0;
      r_rd_bank <= BANK_0;
      r_rd_cnt  <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_in_beat) begin
        r_wr_cnt <= r_wr_cnt + 6'd1;
        if (r_wr_cnt == CNT_LAST) begin
          r_wr_bank <= other_bank(r_wr_bank);
        end
      end
      if (w_out_beat) begin
        r_rd_cnt <= r_rd_cnt + 6'd1;
        if (r_rd_cnt == CNT_LAST) begin
          r_rd_bank <= other_bank(r_rd_bank);
        end
      end
    end
  end

  pingpong_bank #(
    .WIDTH (WIDTH)
  ) u_bank (
    .clk       (clk),
    .i_we      (w_in_beat),
    .i_wr_bank (r_wr_bank),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (in),
    .i_rd_bank (r_rd_bank),
    .i_rd_addr (r_rd_cnt),
    .o_rd_data (w_rd_data)
  );

endmodule
